// File: rtl/sdram_arb_pkg.sv
// Shared types for the sdram ROM arbiter: FSM states and the command-owner encoding.
// Owner values 0..NUM_PORTS-1 name a read port; OWNER_DL marks a download write.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam int NUM_PORTS_DEF = 4;
    localparam int OWNER_DL      = NUM_PORTS_DEF;

    typedef logic [$clog2(NUM_PORTS_DEF + 1)-1:0] owner_t;

endpackage

// File: rtl/rom_port_buffer.sv
// One-word tagged read buffer for a ROM port; hit is combinational against the live address.
// Fill lands one cycle after the fill strobe; clear wins over a simultaneous fill.
module rom_port_buffer #(
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  fill,
    input  logic [ADDR_WIDTH-1:0] fill_addr,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] data
);

    logic [ADDR_WIDTH-1:0] tag;
    logic                  tag_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag       <= '0;
            tag_valid <= 1'b0;
            data      <= '0;
        end else begin
            if (fill) begin
                tag  <= fill_addr;
                data <= fill_data;
            end
            // A fill racing with a content change must not resurrect stale data.
            if (clear)
                tag_valid <= 1'b0;
            else if (fill)
                tag_valid <= 1'b1;
        end
    end

    assign hit = tag_valid && (tag == addr);

endmodule

// File: rtl/sdram_rom_arbiter.sv
// Shares one sdram controller between the ROM download writer and NUM_PORTS buffered read ports.
// Miss-to-req 1 cycle, sdram_valid-to-rom_valid 1 cycle; one command outstanding, req held until ack.
module sdram_rom_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS  = NUM_PORTS_DEF,
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            dl_active,
    input  logic                            dl_req,
    input  logic [ADDR_WIDTH-1:0]           dl_addr,
    input  logic [DATA_WIDTH-1:0]           dl_data,
    output logic                            dl_ack,
    input  logic [NUM_PORTS-1:0]            rom_cs,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] rom_addr,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] rom_data,
    output logic [NUM_PORTS-1:0]            rom_valid,
    output logic [ADDR_WIDTH-1:0]           sdram_addr,
    output logic [DATA_WIDTH-1:0]           sdram_data,
    output logic                            sdram_we,
    output logic                            sdram_req,
    input  logic                            sdram_ack,
    input  logic                            sdram_valid,
    input  logic [DATA_WIDTH-1:0]           sdram_q
);

    localparam int OWNER_W = $clog2(NUM_PORTS + 1);
    localparam logic [OWNER_W-1:0] OWN_DL = OWNER_W'(NUM_PORTS);

    state_t                state, state_nxt;
    logic [OWNER_W-1:0]    owner, owner_nxt;
    logic [ADDR_WIDTH-1:0] lat_addr, lat_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic                  we_nxt, req_nxt, dl_ack_nxt;
    logic                  dl_active_q;
    logic                  fill_en;
    logic                  tag_clear;

    logic [NUM_PORTS-1:0]  hit;
    logic [NUM_PORTS-1:0]  pending;
    logic [NUM_PORTS-1:0]  fill_vec;
    logic [ADDR_WIDTH-1:0] port_addr [NUM_PORTS];

    logic                  any_pending;
    logic [OWNER_W-1:0]    grant;
    logic [ADDR_WIDTH-1:0] grant_addr;

    assign tag_clear = dl_active && !dl_active_q;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign port_addr[i] = rom_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign fill_vec[i]  = fill_en && (owner == OWNER_W'(i));
        assign pending[i]   = rom_cs[i] && !hit[i] && !dl_active;
        assign rom_valid[i] = rom_cs[i] && hit[i];

        rom_port_buffer #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_buf (
            .clk       (clk),
            .reset_n   (reset_n),
            .clear     (tag_clear),
            .fill      (fill_vec[i]),
            .fill_addr (lat_addr),
            .fill_data (sdram_q),
            .addr      (port_addr[i]),
            .hit       (hit[i]),
            .data      (rom_data[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Fixed priority: scan from the top so the lowest pending index wins.
    always_comb begin
        grant       = '0;
        grant_addr  = '0;
        any_pending = |pending;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant      = OWNER_W'(i);
                grant_addr = port_addr[i];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        lat_nxt    = lat_addr;
        addr_nxt   = sdram_addr;
        data_nxt   = sdram_data;
        we_nxt     = sdram_we;
        req_nxt    = sdram_req;
        dl_ack_nxt = 1'b0;
        fill_en    = 1'b0;

        case (state)
            IDLE: begin
                if (dl_active && dl_req) begin
                    addr_nxt  = dl_addr;
                    data_nxt  = dl_data;
                    we_nxt    = 1'b1;
                    req_nxt   = 1'b1;
                    owner_nxt = OWN_DL;
                    state_nxt = REQ;
                end else if (any_pending) begin
                    addr_nxt  = grant_addr;
                    lat_nxt   = grant_addr;
                    we_nxt    = 1'b0;
                    req_nxt   = 1'b1;
                    owner_nxt = grant;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (sdram_ack) begin
                    req_nxt = 1'b0;
                    if (owner == OWN_DL) begin
                        dl_ack_nxt = 1'b1;
                        state_nxt  = IDLE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                // Fill under the latched address even if the port moved on meanwhile.
                if (sdram_valid) begin
                    fill_en   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            owner       <= '0;
            lat_addr    <= '0;
            sdram_addr  <= '0;
            sdram_data  <= '0;
            sdram_we    <= 1'b0;
            sdram_req   <= 1'b0;
            dl_ack      <= 1'b0;
            dl_active_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            lat_addr    <= lat_nxt;
            sdram_addr  <= addr_nxt;
            sdram_data  <= data_nxt;
            sdram_we    <= we_nxt;
            sdram_req   <= req_nxt;
            dl_ack      <= dl_ack_nxt;
            dl_active_q <= dl_active;
        end
    end

endmodule

// File: tb/tb_sdram_rom_arbiter.sv
// Bench for sdram_rom_arbiter: behavioural sdram memory plus a per-port buffer model.
module tb_sdram_rom_arbiter;

    localparam int NP = 4;
    localparam int AW = 23;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             dl_active, dl_req, dl_ack;
    logic [AW-1:0]    dl_addr;
    logic [DW-1:0]    dl_data;
    logic [NP-1:0]    rom_cs, rom_valid;
    logic [NP*AW-1:0] rom_addr;
    logic [NP*DW-1:0] rom_data;
    logic [AW-1:0]    sdram_addr;
    logic [DW-1:0]    sdram_data, sdram_q;
    logic             sdram_we, sdram_req, sdram_ack, sdram_valid;

    sdram_rom_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .dl_active(dl_active), .dl_req(dl_req), .dl_addr(dl_addr), .dl_data(dl_data), .dl_ack(dl_ack),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_valid(rom_valid),
        .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_we(sdram_we), .sdram_req(sdram_req),
        .sdram_ack(sdram_ack), .sdram_valid(sdram_valid), .sdram_q(sdram_q)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int stab_err = 0;
    int req_rises = 0;
    int dl_ack_cnt = 0;
    logic req_prev = 1'b0;

    logic [DW-1:0] mem [logic [AW-1:0]];

    // Buffer model: what each port should currently hold.
    logic          mv [NP];
    logic [AW-1:0] mt [NP];
    logic [DW-1:0] md [NP];

    always @(negedge clk) begin
        if (sdram_req && !req_prev) req_rises++;
        req_prev = sdram_req;
        if (dl_ack) dl_ack_cnt++;
    end

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[7:0], a[15:8], 1'b0, a[22:16], 8'hC3};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int p, input logic [AW-1:0] a);
        rom_addr[p*AW +: AW] = a;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        dl_active = 0; dl_req = 0; dl_addr = '0; dl_data = '0;
        rom_cs = '0; rom_addr = '0;
        sdram_ack = 0; sdram_valid = 0; sdram_q = '0;
        for (int i = 0; i < NP; i++) mv[i] = 1'b0;
        repeat (2) step;
        reset_n = 1'b1;
        step;
    endtask

    // Sdram controller model: serves one command. hook 1 moves a port address once the
    // read is accepted; hook 2 drops dl_active while the command is still requesting.
    task automatic serve(input int ack_dly, input int val_dly, input int hook, input int hook_port,
                         input logic [AW-1:0] hook_addr, output logic [AW-1:0] a,
                         output logic we_o, output logic [DW-1:0] d, output int lat);
        lat = 0;
        a = '0; we_o = 1'b0; d = '0;
        while (sdram_req !== 1'b1 && lat < 50) begin
            step;
            lat++;
        end
        if (sdram_req !== 1'b1) begin
            tests++; fails++;
            $display("FAIL serve_timeout: sdram_req=%b after %0d cycles, want 1", sdram_req, lat);
            lat = -1;
        end else begin
            a = sdram_addr; we_o = sdram_we; d = sdram_data;
            if (hook == 2) dl_active = 1'b0;
            for (int k = 0; k < ack_dly; k++) begin
                step;
                if (sdram_req !== 1'b1 || sdram_addr !== a || sdram_we !== we_o ||
                    (we_o && sdram_data !== d)) stab_err++;
            end
            sdram_ack = 1'b1;
            step;
            sdram_ack = 1'b0;
            if (we_o) begin
                mem[a] = d;
            end else begin
                if (hook == 1) set_addr(hook_port, hook_addr);
                repeat (val_dly) step;
                sdram_valid = 1'b1;
                sdram_q = mem_rd(a);
                step;
                sdram_valid = 1'b0;
                sdram_q = $urandom;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        dl_active = 0; dl_req = 0; dl_addr = '0; dl_data = '0;
        rom_cs = '1; rom_addr = '0;
        sdram_ack = 0; sdram_valid = 0; sdram_q = '0;
        #1;
        tests++;
        if ({sdram_req, sdram_we, dl_ack} !== 3'b000) begin
            fails++; $display("FAIL reset_ctrl: req/we/dl_ack=%b want 000", {sdram_req, sdram_we, dl_ack});
        end
        tests++;
        if (sdram_addr !== '0 || sdram_data !== '0) begin
            fails++; $display("FAIL reset_bus: addr=%h data=%h want 0", sdram_addr, sdram_data);
        end
        tests++;
        if (rom_valid !== 4'b0000 || rom_data !== '0) begin
            fails++; $display("FAIL reset_rom: valid=%b data=%h want 0", rom_valid, rom_data);
        end
        step;
        rom_cs = '0;
        reset_n = 1'b1;
        step;
    endtask

    task automatic test_download;
        logic [AW-1:0] a; logic we; logic [DW-1:0] d; int lat; int acks0;
        acks0 = dl_ack_cnt;
        stab_err = 0;
        dl_active = 1; dl_req = 1; dl_addr = 23'h000010; dl_data = 32'hDEADBEEF;
        rom_cs[0] = 1'b1; set_addr(0, 23'h000030);
        serve(3, 0, 0, 0, '0, a, we, d, lat);
        tests++;
        if (a !== 23'h000010 || we !== 1'b1 || d !== 32'hDEADBEEF || lat != 1) begin
            fails++; $display("FAIL dl_cmd: addr=%h we=%b data=%h lat=%0d want 000010 1 deadbeef 1", a, we, d, lat);
        end
        tests++;
        if (dl_ack !== 1'b1) begin
            fails++; $display("FAIL dl_ack_pulse: dl_ack=%b want 1", dl_ack);
        end
        dl_req = 0;
        rom_cs = '0;
        // Second write: dl_active falls while the write is still requesting.
        dl_req = 1; dl_addr = 23'h000020; dl_data = 32'h12345678;
        serve(2, 0, 2, 0, '0, a, we, d, lat);
        dl_req = 0;
        tests++;
        if (dl_ack !== 1'b1 || a !== 23'h000020 || d !== 32'h12345678) begin
            fails++; $display("FAIL dl_drop: dl_ack=%b addr=%h data=%h want 1 000020 12345678", dl_ack, a, d);
        end
        repeat (4) step;
        tests++;
        if (dl_ack_cnt - acks0 != 2 || stab_err != 0) begin
            fails++; $display("FAIL dl_count: acks=%0d unstable=%0d want 2 0", dl_ack_cnt - acks0, stab_err);
        end
    endtask

    task automatic test_miss_hit;
        logic [AW-1:0] a; logic we; logic [DW-1:0] d; int lat; int r0;
        rom_cs[0] = 1'b1; set_addr(0, 23'h000010);
        serve(1, 5, 0, 0, '0, a, we, d, lat);
        tests++;
        if (a !== 23'h000010 || we !== 1'b0 || lat != 1) begin
            fails++; $display("FAIL miss_cmd: addr=%h we=%b lat=%0d want 000010 0 1", a, we, lat);
        end
        tests++;
        if (rom_valid[0] !== 1'b1 || rom_data[0 +: DW] !== 32'hDEADBEEF) begin
            fails++; $display("FAIL miss_fill: valid=%b data=%h want 1 deadbeef", rom_valid[0], rom_data[0 +: DW]);
        end
        r0 = req_rises;
        repeat (6) step;
        tests++;
        if (req_rises != r0 || rom_valid[0] !== 1'b1) begin
            fails++; $display("FAIL hit_noreq: new reqs=%0d valid=%b want 0 1", req_rises - r0, rom_valid[0]);
        end
        rom_cs = '0;
    endtask

    task automatic test_priority;
        logic [AW-1:0] a; logic we; logic [DW-1:0] d; int lat;
        rom_cs = 4'b1010; set_addr(1, 23'h000200); set_addr(3, 23'h000300);
        serve(0, 2, 0, 0, '0, a, we, d, lat);
        tests++;
        if (a !== 23'h000200 || rom_valid !== 4'b0010 || rom_data[1*DW +: DW] !== mem_rd(23'h000200)) begin
            fails++; $display("FAIL prio_first: addr=%h valid=%b data=%h want 000200 0010 %h",
                              a, rom_valid, rom_data[1*DW +: DW], mem_rd(23'h000200));
        end
        serve(2, 1, 0, 0, '0, a, we, d, lat);
        tests++;
        if (a !== 23'h000300 || lat != 1 || rom_valid !== 4'b1010 ||
            rom_data[3*DW +: DW] !== mem_rd(23'h000300) || rom_data[1*DW +: DW] !== mem_rd(23'h000200)) begin
            fails++; $display("FAIL prio_second: addr=%h lat=%0d valid=%b d3=%h d1=%h", a, lat, rom_valid,
                              rom_data[3*DW +: DW], rom_data[1*DW +: DW]);
        end
        rom_cs = '0;
    endtask

    task automatic test_addr_change;
        logic [AW-1:0] a; logic we; logic [DW-1:0] d; int lat;
        rom_cs[2] = 1'b1; set_addr(2, 23'h000100);
        serve(1, 3, 1, 2, 23'h000104, a, we, d, lat);
        tests++;
        if (a !== 23'h000100 || rom_valid[2] !== 1'b0) begin
            fails++; $display("FAIL chg_stale: addr=%h valid=%b want 000100 0", a, rom_valid[2]);
        end
        set_addr(2, 23'h000100);
        #1;
        tests++;
        if (rom_valid[2] !== 1'b1 || rom_data[2*DW +: DW] !== mem_rd(23'h000100)) begin
            fails++; $display("FAIL chg_tag: valid=%b data=%h want 1 %h", rom_valid[2], rom_data[2*DW +: DW],
                              mem_rd(23'h000100));
        end
        set_addr(2, 23'h000104);
        #1;
        serve(0, 0, 0, 0, '0, a, we, d, lat);
        tests++;
        if (a !== 23'h000104 || lat != 1 || rom_valid[2] !== 1'b1 || rom_data[2*DW +: DW] !== mem_rd(23'h000104)) begin
            fails++; $display("FAIL chg_refetch: addr=%h lat=%0d valid=%b data=%h", a, lat, rom_valid[2],
                              rom_data[2*DW +: DW]);
        end
        rom_cs = '0;
    endtask

    task automatic test_dl_mask;
        logic [AW-1:0] a; logic we; logic [DW-1:0] d; int lat; int r0;
        rom_cs[0] = 1'b1; set_addr(0, 23'h000010);
        #1;
        tests++;
        if (rom_valid[0] !== 1'b1) begin
            fails++; $display("FAIL mask_prehit: valid=%b want 1", rom_valid[0]);
        end
        dl_active = 1'b1;
        step;
        tests++;
        if (rom_valid[0] !== 1'b0) begin
            fails++; $display("FAIL mask_clear: valid=%b want 0", rom_valid[0]);
        end
        set_addr(0, 23'h000040);
        r0 = req_rises;
        repeat (5) step;
        tests++;
        if (req_rises != r0 || sdram_req !== 1'b0) begin
            fails++; $display("FAIL mask_noreq: new reqs=%0d req=%b want 0 0", req_rises - r0, sdram_req);
        end
        dl_active = 1'b0;
        serve(1, 1, 0, 0, '0, a, we, d, lat);
        tests++;
        if (a !== 23'h000040 || lat != 1 || rom_valid[0] !== 1'b1) begin
            fails++; $display("FAIL mask_release: addr=%h lat=%0d valid=%b want 000040 1 1", a, lat, rom_valid[0]);
        end
        rom_cs = '0;
    endtask

    task automatic test_reset_mid;
        logic [AW-1:0] a; logic we; logic [DW-1:0] d; int lat; int r0;
        rom_cs[1] = 1'b1; set_addr(1, 23'h000500);
        step;
        sdram_ack = 1'b1;
        step;
        sdram_ack = 1'b0;
        step;
        reset_n = 1'b0;
        #1;
        tests++;
        if (sdram_req !== 1'b0 || rom_valid !== 4'b0000) begin
            fails++; $display("FAIL rst_wait: req=%b valid=%b want 0 0000", sdram_req, rom_valid);
        end
        reset_n = 1'b1;
        step;
        tests++;
        if (sdram_req !== 1'b1) begin
            fails++; $display("FAIL rst_reissue: req=%b want 1", sdram_req);
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if (sdram_req !== 1'b0) begin
            fails++; $display("FAIL rst_req_drop: req=%b want 0", sdram_req);
        end
        rom_cs = '0;
        reset_n = 1'b1;
        step;
        r0 = req_rises;
        sdram_valid = 1'b1; sdram_q = 32'hBADC0DE5;
        step;
        sdram_valid = 1'b0;
        step;
        rom_cs[1] = 1'b1;
        #1;
        tests++;
        if (req_rises != r0 || rom_valid[1] !== 1'b0) begin
            fails++; $display("FAIL rst_late_valid: new reqs=%0d valid=%b want 0 0", req_rises - r0, rom_valid[1]);
        end
        serve(0, 1, 0, 0, '0, a, we, d, lat);
        tests++;
        if (a !== 23'h000500 || lat != 1 || rom_data[1*DW +: DW] !== mem_rd(23'h000500)) begin
            fails++; $display("FAIL rst_recover: addr=%h lat=%0d data=%h", a, lat, rom_data[1*DW +: DW]);
        end
        rom_cs = '0;
    endtask

    task automatic test_random;
        logic [AW-1:0] a; logic we; logic [DW-1:0] d; int lat; int r0; int p; int guard;
        logic [AW-1:0] aset [6];
        logic [AW-1:0] pa;
        logic ev;
        logic [NP-1:0] pend;
        aset[0] = 23'h000010; aset[1] = 23'h000020; aset[2] = 23'h000104;
        aset[3] = 23'h000200; aset[4] = 23'h7FFFFF; aset[5] = 23'h400000;
        do_reset;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(3) == 0) begin
                dl_active = 1'b1;
                for (int i = 0; i < NP; i++) mv[i] = 1'b0;
                step;
                tests++;
                if (rom_valid !== 4'b0000) begin
                    fails++; $display("FAIL rnd_dl_clear it%0d: valid=%b want 0000", it, rom_valid);
                end
                dl_req = 1; dl_addr = aset[$urandom_range(5)]; dl_data = $urandom;
                serve($urandom_range(3), 0, 0, 0, '0, a, we, d, lat);
                tests++;
                if (a !== dl_addr || we !== 1'b1 || d !== dl_data || dl_ack !== 1'b1) begin
                    fails++; $display("FAIL rnd_dl it%0d: addr=%h we=%b data=%h ack=%b", it, a, we, d, dl_ack);
                end
                dl_req = 0;
                dl_active = 0;
            end
            rom_cs = NP'($urandom_range(15));
            for (int i = 0; i < NP; i++) set_addr(i, aset[$urandom_range(5)]);
            guard = 0;
            do begin
                pend = '0;
                for (int i = 0; i < NP; i++)
                    pend[i] = rom_cs[i] && !(mv[i] && mt[i] == rom_addr[i*AW +: AW]);
                if (pend != '0) begin
                    p = 0;
                    while (!pend[p]) p++;
                    pa = rom_addr[p*AW +: AW];
                    serve($urandom_range(3), $urandom_range(4), 0, 0, '0, a, we, d, lat);
                    tests++;
                    if (a !== pa || we !== 1'b0 || lat != 1) begin
                        fails++; $display("FAIL rnd_grant it%0d: addr=%h we=%b lat=%0d want %h 0 1 (port %0d)",
                                          it, a, we, lat, pa, p);
                    end
                    mv[p] = 1'b1; mt[p] = pa; md[p] = mem_rd(pa);
                    for (int i = 0; i < NP; i++) begin
                        ev = rom_cs[i] && mv[i] && mt[i] == rom_addr[i*AW +: AW];
                        tests++;
                        if (rom_valid[i] !== ev || (ev && rom_data[i*DW +: DW] !== md[i])) begin
                            fails++; $display("FAIL rnd_port it%0d p%0d: valid=%b data=%h want %b %h",
                                              it, i, rom_valid[i], rom_data[i*DW +: DW], ev, md[i]);
                        end
                    end
                end
                guard++;
            end while (pend != '0 && guard <= NP + 1);
            r0 = req_rises;
            repeat (3) step;
            tests++;
            if (req_rises != r0) begin
                fails++; $display("FAIL rnd_idle it%0d: %0d extra reqs want 0", it, req_rises - r0);
            end
        end
        rom_cs = '0;
    endtask

    initial begin
        test_reset;
        test_download;
        test_miss_hit;
        test_priority;
        test_addr_change;
        test_dl_mask;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
